dds_wave_gen: RTL and testbench

DDS_WAVE_GEN -- requirements
Module: dds_wave_gen

---
 rtl/dds_wave_gen.sv | 107 ++++++++++
 tb/tb_dds_wave_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator feeding a two-stage sine/triangle/sawtooth/square shaper.
// Define DDS_SYNC_SWITCH_EN to defer waveform switches to the accumulator wrap (glitch-free period).
`timescale 1ns/1ps
module dds_wave_gen #(
  parameter int unsigned      ACC_W  = 32,
  parameter logic [ACC_W-1:0] FW_RST = ACC_W'(32'h0100_0000)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [1:0]       wave_c,
  input  logic [ACC_W-1:0] fw_in,
  input  logic             fw_load,
  input  logic             en,
  output logic [7:0]       dac_data,
  output logic             dac_valid,
  output logic [1:0]       wave_active,
  output logic             phase_wrap
);

  localparam logic [1:0] WAVE_SINE = 2'b00;
  localparam logic [1:0] WAVE_TRI  = 2'b01;
  localparam logic [1:0] WAVE_SAW  = 2'b10;
  localparam logic [1:0] WAVE_SQR  = 2'b11;

  // Quarter-wave magnitude m(k) = round(127*sin(pi/2*(k+0.5)/64)), sampled at bin centres.
  localparam logic [6:0] QTAB [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fw;
  logic [ACC_W:0]   sum;
  logic             wave_load;

  logic [7:0]       p_s1;
  logic [1:0]       wave_s1;
  logic             en_s1;

  logic [5:0]       idx;
  logic [6:0]       mag;
  logic [7:0]       sample;

  always_comb begin
    sum = {1'b0, acc} + {1'b0, fw};
  end

`ifdef DDS_SYNC_SWITCH_EN
  // Switch only when the period restarts, or freely while the accumulator is stopped.
  always_comb begin
    wave_load = ~en | sum[ACC_W];
  end
`else
  always_comb begin
    wave_load = 1'b1;
  end
`endif

  always_comb begin
    idx    = p_s1[6] ? ~p_s1[5:0] : p_s1[5:0];
    mag    = QTAB[idx];
    sample = p_s1;
    case (wave_s1)
      WAVE_SINE: sample = p_s1[7] ? (8'd127 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
      WAVE_TRI:  sample = p_s1[7] ? ~{p_s1[6:0], 1'b0} : {p_s1[6:0], 1'b0};
      WAVE_SAW:  sample = p_s1;
      WAVE_SQR:  sample = {8{~p_s1[7]}};
      default:   sample = p_s1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc         <= '0;
      fw          <= FW_RST;
      wave_active <= WAVE_SINE;
      phase_wrap  <= 1'b0;
      p_s1        <= '0;
      wave_s1     <= WAVE_SINE;
      en_s1       <= 1'b0;
      dac_data    <= 8'd128;
      dac_valid   <= 1'b0;
    end else begin
      if (en)
        acc <= sum[ACC_W-1:0];
      if (fw_load)
        fw <= fw_in;
      if (wave_load)
        wave_active <= wave_c;
      phase_wrap <= en & sum[ACC_W];
      p_s1       <= acc[ACC_W-1 -: 8];
      wave_s1    <= wave_active;
      en_s1      <= en;
      dac_valid  <= en_s1;
      // Samples from stopped cycles are dropped so the output holds the last live sample.
      if (en_s1)
        dac_data <= sample;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: arithmetic reference model with a 2-cycle sample queue,
// directed scenarios, literal pins on known sample points, then randomized stimulus.
`timescale 1ns/1ps
module tb_dds_wave_gen;

  typedef struct packed {
    logic       en;
    logic [1:0] wave;
    logic [7:0] p;
  } desc_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  wave_c;
  logic [31:0] fw_in;
  logic        fw_load;
  logic        en;
  logic [7:0]  dac_data;
  logic        dac_valid;
  logic [1:0]  wave_active;
  logic        phase_wrap;

  dds_wave_gen #(.ACC_W(32), .FW_RST(32'h0100_0000)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .wave_c      (wave_c),
    .fw_in       (fw_in),
    .fw_load     (fw_load),
    .en          (en),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid),
    .wave_active (wave_active),
    .phase_wrap  (phase_wrap)
  );

  always #5 sys_clk = ~sys_clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          m_tab [64];
  logic [31:0] m_acc;
  logic [31:0] m_fw;
  logic [1:0]  m_wave;
  logic [7:0]  m_dac;
  logic        m_valid;
  logic        m_wrap;
  desc_t       pipe [$];
  logic        pin_hit;
  logic [7:0]  pin_val;

  function automatic logic [7:0] shape(logic [1:0] w, logic [7:0] p);
    int pi_ = int'(p);
    int q   = pi_ / 64;
    int i   = pi_ % 64;
    int r;
    case (w)
      2'd0: begin
        case (q)
          0:       r = 128 + m_tab[i];
          1:       r = 128 + m_tab[63 - i];
          2:       r = 127 - m_tab[i];
          default: r = 127 - m_tab[63 - i];
        endcase
      end
      2'd1:    r = (pi_ < 128) ? 2 * pi_ : 255 - 2 * (pi_ - 128);
      2'd2:    r = pi_;
      default: r = (pi_ < 128) ? 255 : 0;
    endcase
    return 8'(r);
  endfunction

  // Hand-computed sample points that pin the model itself.
  task automatic lit(input logic [1:0] w, input logic [7:0] p, output logic hit, output logic [7:0] v);
    hit = 1'b1;
    v   = 8'd0;
    case ({w, p})
      {2'd0, 8'd0}:   v = 8'd130;
      {2'd0, 8'd64}:  v = 8'd255;
      {2'd0, 8'd128}: v = 8'd125;
      {2'd0, 8'd192}: v = 8'd0;
      {2'd1, 8'd127}: v = 8'd254;
      {2'd1, 8'd128}: v = 8'd255;
      {2'd1, 8'd255}: v = 8'd1;
      {2'd2, 8'd0}:   v = 8'd0;
      {2'd2, 8'd255}: v = 8'd255;
      {2'd3, 8'd0}:   v = 8'd255;
      {2'd3, 8'd128}: v = 8'd0;
      default:        hit = 1'b0;
    endcase
  endtask

  task automatic model_step();
    logic [32:0] sum;
    desc_t       d;
    pin_hit = 1'b0;
    if (sys_rst) begin
      m_acc   = '0;
      m_fw    = 32'h0100_0000;
      m_wave  = 2'd0;
      m_dac   = 8'd128;
      m_valid = 1'b0;
      m_wrap  = 1'b0;
      pipe.delete();
      pipe.push_back('0);
    end else begin
      d = pipe.pop_front();
      if (d.en) begin
        m_dac = shape(d.wave, d.p);
        lit(d.wave, d.p, pin_hit, pin_val);
      end
      m_valid = d.en;
      pipe.push_back(desc_t'({en, m_wave, m_acc[31:24]}));
      sum    = {1'b0, m_acc} + {1'b0, m_fw};
      m_wrap = en && sum[32];
`ifdef DDS_SYNC_SWITCH_EN
      if (!en || sum[32])
        m_wave = wave_c;
`else
      m_wave = wave_c;
`endif
      if (en)
        m_acc = sum[31:0];
      if (fw_load)
        m_fw = fw_in;
    end
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
    cmp("dac_data", dac_data, m_dac);
    cmp("dac_valid", 8'(dac_valid), 8'(m_valid));
    cmp("wave_active", 8'(wave_active), 8'(m_wave));
    cmp("phase_wrap", 8'(phase_wrap), 8'(m_wrap));
    if (pin_hit)
      cmp("pin_sample", dac_data, pin_val);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    fw_load = 1'b0;
    tick();
    cmp("rst_dac", dac_data, 8'd128);
    cmp("rst_valid", 8'(dac_valid), 8'd0);
    cmp("rst_wave", 8'(wave_active), 8'd0);
    cmp("rst_wrap", 8'(phase_wrap), 8'd0);
    sys_rst = 1'b0;
    en      = 1'b0;
  endtask

  task automatic load_fw(input logic [31:0] f);
    fw_in   = f;
    fw_load = 1'b1;
    tick();
    fw_load = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 64; k++)
      m_tab[k] = $rtoi(127.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 128.0) + 0.5);
    pipe.push_back('0);
    sys_rst = 1'b1; en = 1'b0; wave_c = 2'd0; fw_in = '0; fw_load = 1'b0;
    m_acc = '0; m_fw = 32'h0100_0000; m_wave = '0; m_dac = 8'd128; m_valid = 1'b0; m_wrap = 1'b0;

    // Sawtooth ramp over a full period and a bit.
    do_reset();
    wave_c = 2'd2;
    run(2);
    en = 1'b1;
    run(260);

    // Sine at 4x step.
    do_reset();
    wave_c = 2'd0;
    load_fw(32'h0400_0000);
    en = 1'b1;
    run(70);

    // Triangle over a full period.
    do_reset();
    wave_c = 2'd1;
    tick();
    en = 1'b1;
    run(260);

    // Square at 4x step.
    do_reset();
    wave_c = 2'd3;
    load_fw(32'h0400_0000);
    en = 1'b1;
    run(70);

    // Sine -> square request mid-period.
    do_reset();
    wave_c = 2'd0;
    load_fw(32'h0400_0000);
    en = 1'b1;
    for (int k = 0; k < 100 && m_acc[31:24] != 8'h40; k++)
      tick();
    if (m_acc[31:24] != 8'h40) begin
      vectors++;
      miscompares++;
      $display("FAIL reach_p40: got %0d expected 64", m_acc[31:24]);
    end
    wave_c = 2'd3;
    run(80);

    // fw_load coinciding with the wrap step: that step still uses the old word.
    do_reset();
    wave_c = 2'd2;
    tick();
    en = 1'b1;
    run(255);
    load_fw(32'h0080_0000);
    cmp("wrap_old_fw", 8'(phase_wrap), 8'd1);
    run(20);

    // Reset mid-run at p=0x80.
    do_reset();
    wave_c = 2'd2;
    tick();
    en = 1'b1;
    run(128);
    en = 1'b1;
    sys_rst = 1'b1;
    tick();
    cmp("midrst_dac", dac_data, 8'd128);
    cmp("midrst_valid", 8'(dac_valid), 8'd0);
    sys_rst = 1'b0;
    run(20);

    // Pause with a waveform change while stopped.
    en = 1'b0;
    run(4);
    wave_c = 2'd1;
    run(6);
    en = 1'b1;
    run(20);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      sys_rst = ($urandom_range(0, 499) == 0);
      en      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0)
        wave_c = 2'($urandom_range(0, 3));
      fw_load = ($urandom_range(0, 31) == 0);
      fw_in   = (($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> 6));
      tick();
    end
    sys_rst = 1'b0;
    fw_load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
